// File: rtl/float32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float32_pkg
// Description : Shared binary32 constants and the integer-to-float FSM state
//               type used by the float32 datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package float32_pkg;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_W   = 8;
    localparam int FP32_MAN_W   = 23;
    // Exponent of a value whose leading one sits at bit 31 of the magnitude.
    localparam int I2F_EXP_INIT = FP32_BIAS + 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } i2f_state_t;

endpackage
`default_nettype wire

// File: rtl/fp32_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : fp32_round_rne
// Description : Combinational round-to-nearest-even of a normalised
//               {hidden, mantissa} with guard/sticky, including exponent carry.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_round_rne
    import float32_pkg::*;
(
    input  logic [FP32_MAN_W:0]   i_man,
    input  logic                  i_guard,
    input  logic                  i_sticky,
    input  logic [FP32_EXP_W-1:0] i_exp,
    output logic [FP32_MAN_W-1:0] o_man,
    output logic [FP32_EXP_W-1:0] o_exp,
    output logic                  o_inexact
);

    logic                  w_round_up;
    logic                  w_carry;
    logic [FP32_MAN_W:0]   w_sum;

    assign w_round_up = i_guard & (i_sticky | i_man[0]);
    assign {w_carry, w_sum} = {1'b0, i_man} + {{(FP32_MAN_W + 1){1'b0}}, w_round_up};

    // A carry out of the hidden bit renormalises by one place.
    assign o_man     = w_carry ? w_sum[FP32_MAN_W:1] : w_sum[FP32_MAN_W-1:0];
    assign o_exp     = i_exp + {{(FP32_EXP_W - 1){1'b0}}, w_carry};
    assign o_inexact = i_guard | i_sticky;

endmodule
`default_nettype wire

// File: rtl/int_to_float32_serial.sv
`default_nettype none
// ============================================================================
// Module      : int_to_float32_serial
// Description : 32-bit integer to binary32 converter, RNE rounding, normalising
//               one bit per clock behind valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module int_to_float32_serial
    import float32_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact
);

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_norm  = NORM;
    localparam logic [1:0] c_st_round = ROUND;
    localparam logic [1:0] c_st_done  = DONE;

    logic [1:0]            r_state;
    logic                  r_sign;
    logic [31:0]           r_mag;
    logic [FP32_EXP_W-1:0] r_exp;
    logic [31:0]           r_out_data;
    logic                  r_out_inexact;

    logic                  w_sign_in;
    logic [31:0]           w_mag_in;
    logic [FP32_MAN_W-1:0] w_rnd_man;
    logic [FP32_EXP_W-1:0] w_rnd_exp;
    logic                  w_rnd_inexact;

    assign w_sign_in = SIGNED_IN ? in_data[31] : 1'b0;
    // Negating -2^31 wraps back to 0x80000000, which is the correct magnitude.
    assign w_mag_in  = w_sign_in ? (~in_data + 32'd1) : in_data;

    fp32_round_rne u_round (
        .i_man     (r_mag[31:8]),
        .i_guard   (r_mag[7]),
        .i_sticky  (|r_mag[6:0]),
        .i_exp     (r_exp),
        .o_man     (w_rnd_man),
        .o_exp     (w_rnd_exp),
        .o_inexact (w_rnd_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_sign        <= 1'b0;
            r_mag         <= 32'd0;
            r_exp         <= '0;
            r_out_data    <= 32'd0;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_sign <= w_sign_in;
                        r_mag  <= w_mag_in;
                        r_exp  <= FP32_EXP_W'(I2F_EXP_INIT);
                        if (w_mag_in == 32'd0) begin
                            r_out_data    <= 32'd0;
                            r_out_inexact <= 1'b0;
                            r_state       <= c_st_done;
                        end else begin
                            r_state <= c_st_norm;
                        end
                    end
                end
                c_st_norm: begin
                    if (r_mag[31]) begin
                        r_state <= c_st_round;
                    end else begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                c_st_round: begin
                    r_out_data    <= {r_sign, w_rnd_exp, w_rnd_man};
                    r_out_inexact <= w_rnd_inexact;
                    r_state       <= c_st_done;
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready    = (r_state == c_st_idle);
    assign out_valid   = (r_state == c_st_done);
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;

endmodule
`default_nettype wire

// File: tb/tb_int_to_float32_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_to_float32_serial
// Description : Self-checking bench for int_to_float32_serial (signed and
//               unsigned instances) against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_int_to_float32_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_out_inexact;
    logic [31:0] s_in_data = 32'd0, s_out_data;
    logic        u_in_valid = 1'b0, u_in_ready, u_out_valid, u_out_ready = 1'b0, u_out_inexact;
    logic [31:0] u_in_data = 32'd0, u_out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_to_float32_serial #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_inexact(s_out_inexact)
    );

    int_to_float32_serial #(.SIGNED_IN(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(u_in_data),
        .out_valid(u_out_valid), .out_ready(u_out_ready),
        .out_data(u_out_data), .out_inexact(u_out_inexact)
    );

    // Reference: exact integer arithmetic on the magnitude, RNE by remainder
    // comparison. lat = clock edges after the accepting edge until out_valid
    // is visible (zero: visible in the first cycle after the accepting edge).
    function automatic void ref_conv(input logic [31:0] x, input bit signed_in,
                                     output logic [31:0] f, output logic inx,
                                     output int lat);
        longint unsigned mag, q, r, half;
        bit sgn;
        int p, sh;
        sgn = signed_in && x[31];
        mag = sgn ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        r = 0;
        if (mag == 0) begin
            f = 32'd0; inx = 1'b0; lat = 0;
            return;
        end
        p = 31;
        while (((mag >> p) & 64'd1) == 0) p--;
        lat = (31 - p) + 2;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            r    = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        f   = {sgn, 8'(127 + p), q[22:0]};
        inx = (r != 0);
    endfunction

    task automatic drive_conv(input bit uns, input logic [31:0] d,
                              output logic [31:0] res, output logic inx,
                              output int lat, output bit ok);
        logic v;
        ok  = 1'b1;
        lat = 0;
        @(negedge clk);
        if (uns) begin u_in_valid = 1'b1; u_in_data = d; end
        else     begin s_in_valid = 1'b1; s_in_data = d; end
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        s_in_valid = 1'b0;
        v = uns ? u_out_valid : s_out_valid;
        while (!v && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            v = uns ? u_out_valid : s_out_valid;
        end
        if (!v) ok = 1'b0;
        res = uns ? u_out_data : s_out_data;
        inx = uns ? u_out_inexact : s_out_inexact;
        if (uns) u_out_ready = 1'b1; else s_out_ready = 1'b1;
        @(posedge clk); #1;
        u_out_ready = 1'b0;
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] res; logic inx; int lat; bit ok; int bad;
        // Power-on reset values.
        #1;
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_data !== 32'd0 || s_out_inexact !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h inexact=%b, want 1 0 00000000 0",
                     s_in_ready, s_out_valid, s_out_data, s_out_inexact);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        // Abort a conversion of 5 mid-flight.
        @(negedge clk); s_in_valid = 1'b1; s_in_data = 32'd5;
        @(posedge clk); #1; s_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_data !== 32'd0 || s_out_inexact !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: in_ready=%b out_valid=%b out_data=%h inexact=%b, want 1 0 00000000 0",
                     s_in_ready, s_out_valid, s_out_data, s_out_inexact);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (s_out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_no_pulse: out_valid high on %0d cycles, want 0", bad);
        end
        drive_conv(1'b0, 32'd2, res, inx, lat, ok);
        checks++;
        if (!ok || res !== 32'h4000_0000 || inx !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_conv2: ok=%0d got %h/%b, want 40000000/0", ok, res, inx);
        end
    endtask

    typedef struct {
        bit          uns;
        logic [31:0] din;
        logic [31:0] exp_f;
        logic        exp_x;
        int          exp_lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[12];
        logic [31:0] res; logic inx; int lat; bit ok;
        vecs[0]  = '{1'b0, 32'd3,          32'h4040_0000, 1'b0, 32};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFF,  32'hBF80_0000, 1'b0, 33};
        vecs[2]  = '{1'b0, 32'd0,          32'h0000_0000, 1'b0, 0};
        vecs[3]  = '{1'b0, 32'h8000_0000,  32'hCF00_0000, 1'b0, 2};
        vecs[4]  = '{1'b0, 32'd16777217,   32'h4B80_0000, 1'b1, 9};
        vecs[5]  = '{1'b0, 32'd16777219,   32'h4B80_0002, 1'b1, 9};
        vecs[6]  = '{1'b0, 32'h7FFF_FFFF,  32'h4F00_0000, 1'b1, 3};
        vecs[7]  = '{1'b0, 32'd1,          32'h3F80_0000, 1'b0, 33};
        vecs[8]  = '{1'b0, 32'h4000_0000,  32'h4E80_0000, 1'b0, 3};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFF,  32'h4F80_0000, 1'b1, 2};
        vecs[10] = '{1'b1, 32'h8000_0000,  32'h4F00_0000, 1'b0, 2};
        vecs[11] = '{1'b1, 32'd0,          32'h0000_0000, 1'b0, 0};
        foreach (vecs[i]) begin
            drive_conv(vecs[i].uns, vecs[i].din, res, inx, lat, ok);
            checks++;
            if (!ok || res !== vecs[i].exp_f || inx !== vecs[i].exp_x || lat != vecs[i].exp_lat) begin
                errors++;
                $display("FAIL directed[%0d] in=%h uns=%0d: got %h/%b lat %0d ok %0d, want %h/%b lat %0d",
                         i, vecs[i].din, vecs[i].uns, res, inx, lat, ok,
                         vecs[i].exp_f, vecs[i].exp_x, vecs[i].exp_lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, res, ef; logic inx, ex; int lat, el; bit ok, uns;
        for (int i = 0; i < 300; i++) begin
            uns = i[0];
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) d = ~d + 32'd1;
            ref_conv(d, !uns, ef, ex, el);
            drive_conv(uns, d, res, inx, lat, ok);
            checks++;
            if (!ok || res !== ef || inx !== ex || lat != el) begin
                errors++;
                $display("FAIL random in=%h uns=%0d: got %h/%b lat %0d ok %0d, want %h/%b lat %0d",
                         d, uns, res, inx, lat, ok, ef, ex, el);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, ef, held; logic ex, held_x; int el, waited, bad;
        d = ($urandom | 32'h0000_0100) >> 3;
        ref_conv(d, 1'b1, ef, ex, el);
        @(negedge clk); s_in_valid = 1'b1; s_in_data = d;
        @(posedge clk); #1; s_in_valid = 1'b0;
        waited = 0;
        while (!s_out_valid && waited < 64) begin
            @(posedge clk); #1; waited++;
        end
        held = s_out_data;
        held_x = s_out_inexact;
        checks++;
        if (s_out_valid !== 1'b1 || held !== ef || held_x !== ex) begin
            errors++;
            $display("FAIL bp_result: valid=%b got %h/%b, want 1 %h/%b", s_out_valid, held, held_x, ef, ex);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            s_in_valid = c[0];
            s_in_data  = 32'd12345 + c;
            @(posedge clk); #1;
            if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 ||
                s_out_data !== ef || s_out_inexact !== ex) bad++;
        end
        s_in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d stalled cycles not frozen, want 0", bad);
        end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", s_out_valid, s_in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_single_handshake: out_valid=%b in_ready=%b, want 0 1", s_out_valid, s_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_to_float32_serial.md
# int_to_float32_serial

Converts a 32-bit integer to IEEE-754 binary32 using round-to-nearest-even. It normalises serially, shifting one bit per clock, to keep area small. It sits directly upstream of the float32 adder/subtractor (`Addition_Subtraction`) and supplies its `a_operand`/`b_operand` from integer sources. Input and output use valid/ready handshakes, and the block processes one conversion at a time.

## Interface
- `SIGNED_IN`, default 1: 1 treats `in_data` as two's complement; 0 treats it as unsigned.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts input. Equals (state == IDLE).
- `in_data` in 32: integer operand.
- `out_valid` out 1: `out_data`/`out_inexact` are valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 32: binary32 result.
- `out_inexact` out 1: rounding discarded nonzero bits.

## Operation
- **IDLE**
  - On `in_valid && in_ready`, capture the sign: `in_data[31]` if `SIGNED_IN`, else 0.
  - Capture `mag` (32-bit unsigned): the negated `in_data` if sign is set, else `in_data`. −2^31 gives `mag` = 0x80000000.
  - Set `exp` = 158 (127+31).
  - If `mag` == 0, go to DONE with `out_data` = 0x00000000 and `out_inexact` = 0. Zero is always +0. Otherwise go to NORM.
- **NORM**
  - If `mag[31]`, go to ROUND.
  - Else `mag <<= 1` and `exp -= 1`. Exactly one shift per cycle.
- **ROUND**
  - Mantissa m = `mag[30:8]`, guard g = `mag[7]`, sticky s = OR of `mag[6:0]`.
  - Round up when g && (s || m[0]).
  - If m is all ones and rounds up, m becomes 0 and `exp` += 1.
  - Register `out_data` = {sign, exp[7:0], m} and `out_inexact` = g | s, then go to DONE.
- **DONE**
  - `out_valid` = 1; `out_data` and `out_inexact` are held stable.
  - On `out_ready`, go to IDLE.
- Overflow is impossible: the maximum result exponent is 159. No NaN, Inf, or denormal outputs are produced.
- Invalid transitions or states recover to IDLE.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_data` 0x00000000, `out_inexact` 0.
- Latency, measured from the accepting edge to `out_valid` high:
  - Nonzero input: lz+2 cycles, where lz is the leading-zero count of `mag` (0..31). Range 2..33.
  - Zero input: 1 cycle.
- Throughput: next input accepted no earlier than the cycle after the output handshake. `in_ready` is low from the accept edge until return to IDLE.
- Backpressure: while `out_valid && !out_ready`, all outputs are frozen and `in_ready` stays 0.
- `in_valid` is ignored outside IDLE. No combinational path from `in_valid` or `out_ready` to any output other than via state.
- Reset mid-operation aborts immediately. The in-flight conversion is dropped and no `out_valid` pulse occurs.

## Structure
- Shared package `float32_pkg`:
  - Constants `FP32_BIAS` = 127, `FP32_EXP_W` = 8, `FP32_MAN_W` = 23, `I2F_EXP_INIT` = 158.
  - Typedef `i2f_state_t` {IDLE, NORM, ROUND, DONE}.
- One combinational sub-module, `fp32_round_rne`:
  - Inputs: 24-bit {hidden, m}, g, s, 8-bit `exp`.
  - Outputs: rounded m, `exp`, inexact.
  - Reused later by the adder's normaliser.

## Test plan
- Reset asserted with `in_data` = 5 in flight → outputs at reset values. After release, a new conversion of 2 → 0x40000000, `out_inexact` 0.
- Exact values:
  - 3 → 0x40400000
  - −1 → 0xBF800000
  - 0 → 0x00000000 with 1-cycle latency
  - `SIGNED_IN` = 1: −2147483648 → 0xCF000000
- Rounding, all with `out_inexact` 1:
  - 16777217 → 0x4B800000 (tie to even, down)
  - 16777219 → 0x4B800002 (tie to even, up)
  - 0x7FFFFFFF → 0x4F000000 (mantissa carry into `exp`)
  - `SIGNED_IN` = 0: 0xFFFFFFFF → 0x4F800000
- Latency: 1 → `out_valid` 33 cycles after accept; 0x40000000 → 3 cycles; 0x80000000 (`SIGNED_IN` = 0) → 2 cycles.
- Backpressure: `out_ready` held low for 5 cycles on a result → `out_data` stable, `in_ready` 0, and `in_valid` pulses ignored. A single handshake when `out_ready` rises, then `in_ready` = 1 the next cycle.
- Chained check: two conversions (2 and 0.75 is impossible, so use 2 and 1) fed to `Addition_Subtraction` → sum 0x40400000.
